// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master arbiter for a single-port data RAM with bounded ownership lock
module ram_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic          m0_lock_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m0_ack_o,
    output logic          m0_stall_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic          m1_lock_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic [DW-1:0] m1_rdata_o,
    output logic          m1_ack_o,
    output logic          m1_stall_o,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_sel_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [1:0]    r_state;
    logic          r_rr_ptr;
    logic          r_owner;
    logic          r_locked;
    logic [CW-1:0] r_lock_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_sel;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic          w_own_req;
    logic          w_own_lock;
    logic          w_hold;
    logic          w_win;
    logic          w_any;
    logic          w_relock;
    logic          w_acc;
    logic          w_resp;

    // Winner selection: a live lock pins the owner, otherwise a lone requester or rr_ptr wins
    always_comb begin
        w_own_req  = r_owner ? m1_req_i : m0_req_i;
        w_own_lock = r_owner ? m1_lock_i : m0_lock_i;
        w_hold     = r_locked & w_own_req;
        w_win      = w_hold ? r_owner : (m0_req_i & m1_req_i) ? r_rr_ptr : m1_req_i;
        w_any      = m0_req_i | m1_req_i;
        w_relock   = w_own_lock && (int'(r_lock_cnt) + 1 < LOCK_MAX);
        w_acc      = (r_state == ACCESS) & ~rst;
        w_resp     = (r_state == RESP) & ~rst;
    end

    assign ram_ce_o   = w_acc;
    assign ram_we_o   = w_acc & r_we;
    assign ram_addr_o = w_acc ? r_addr : '0;
    assign ram_sel_o  = w_acc ? r_sel : '0;
    assign ram_data_o = w_acc ? r_wdata : '0;
    assign m0_ack_o   = w_resp & ~r_owner;
    assign m1_ack_o   = w_resp & r_owner;
    assign m0_stall_o = m0_req_i & ~m0_ack_o;
    assign m1_stall_o = m1_req_i & ~m1_ack_o;
    assign m0_rdata_o = r_m0_rdata;
    assign m1_rdata_o = r_m1_rdata;

    // Three-phase transfer: latch the winner, drive the RAM for one cycle, then ack and update lock state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 1'b0;
            r_owner    <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_sel      <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_locked && !w_own_req) begin
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                    if (w_any) begin
                        r_owner <= w_win;
                        r_we    <= w_win ? m1_we_i : m0_we_i;
                        r_addr  <= w_win ? m1_addr_i : m0_addr_i;
                        r_sel   <= w_win ? m1_sel_i : m0_sel_i;
                        r_wdata <= w_win ? m1_wdata_i : m0_wdata_i;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we && r_owner) r_m1_rdata <= ram_data_i;
                    if (!r_we && !r_owner) r_m0_rdata <= ram_data_i;
                    r_state <= RESP;
                end
                RESP: begin
                    r_locked   <= w_relock;
                    r_lock_cnt <= w_relock ? r_lock_cnt + CW'(1) : '0;
                    if (!w_relock) r_rr_ptr <= ~r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table plus hand sequences for the two-master RAM arbiter, scoreboarded on acks
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_i = 0, m0_we_i = 0, m0_lock_i = 0;
    logic [31:0] m0_addr_i = 0, m0_wdata_i = 0;
    logic [3:0]  m0_sel_i = 0;
    logic [31:0] m0_rdata_o;
    logic        m0_ack_o, m0_stall_o;
    logic        m1_req_i = 0, m1_we_i = 0, m1_lock_i = 0;
    logic [31:0] m1_addr_i = 0, m1_wdata_i = 0;
    logic [3:0]  m1_sel_i = 0;
    logic [31:0] m1_rdata_o;
    logic        m1_ack_o, m1_stall_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        m;
        int          due;
        logic [31:0] rdata;
    } sb_t;

    sb_t         q[$];
    logic [31:0] mem [0:255];
    logic [31:0] last_rd [0:1];
    int          cyc = 0;
    int          n_ack = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i), .m0_addr_i(m0_addr_i),
        .m0_sel_i(m0_sel_i), .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
        .m0_stall_o(m0_stall_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i), .m1_addr_i(m1_addr_i),
        .m1_sel_i(m1_sel_i), .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
        .m1_stall_o(m1_stall_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    assign ram_data_i = mem[ram_addr_o[9:2]];

    // Byte-masked RAM model, written at the closing edge of an ACCESS cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_ce_o && ram_we_o)
            for (int b = 0; b < 4; b++)
                if (ram_sel_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] = ram_data_o[8*b +: 8];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every ack must match the oldest expected transfer in master, cycle and data
    always @(negedge clk) begin
        if (m0_ack_o || m1_ack_o) begin
            chk("dual_ack", 32'(m0_ack_o & m1_ack_o), 32'd0);
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack m0=%b m1=%b (cycle %0d)", m0_ack_o, m1_ack_o, cyc);
            end else begin
                sb_t e;
                e = q.pop_front();
                chk("ack_master", 32'(m1_ack_o), 32'(e.m));
                chk("ack_cycle", 32'(cyc), 32'(e.due));
                chk("ack_rdata", e.m ? m1_rdata_o : m0_rdata_o, e.rdata);
            end
            n_ack++;
        end
    end

    task automatic drive(input logic m, input logic req, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input logic lk);
        if (m) begin
            m1_req_i = req; m1_we_i = we; m1_addr_i = a; m1_sel_i = s; m1_wdata_i = d; m1_lock_i = lk;
        end else begin
            m0_req_i = req; m0_we_i = we; m0_addr_i = a; m0_sel_i = s; m0_wdata_i = d; m0_lock_i = lk;
        end
    endtask

    task automatic expect_ack(input logic m, input int due, input logic we, input logic [31:0] rd);
        sb_t e;
        e.m = m;
        e.due = due;
        e.rdata = we ? last_rd[m] : rd;
        if (!we) last_rd[m] = rd;
        q.push_back(e);
    endtask

    task automatic wait_ack(input int target);
        int b = 0;
        while (n_ack < target && b < 40) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (n_ack < target) chk("ack_timeout", 32'(n_ack), 32'(target));
    endtask

    task automatic idle_all();
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        drive(1'b1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        idle_all();
        @(negedge clk);
        chk("rst_ram", 32'(|{ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o}), 32'd0);
        chk("rst_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        chk("rst_rdata0", m0_rdata_o, 32'd0);
        chk("rst_rdata1", m1_rdata_o, 32'd0);
        #1 rst = 1'b0;
        last_rd[0] = 0;
        last_rd[1] = 0;
    endtask

    initial begin
        vec_t v[6];
        int   c;
        int   tgt;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEADBEEF;
        mem[8'h08] = 32'hAAAAAAAA;
        mem[8'h0C] = 32'h30303030;
        mem[8'h10] = 32'h40404040;
        v[0] = '{m: 1'b0, we: 1'b0, addr: 32'h10, sel: 4'hF, wdata: 32'h0,        exp: 32'hDEADBEEF};
        v[1] = '{m: 1'b1, we: 1'b1, addr: 32'h20, sel: 4'h3, wdata: 32'h12345678, exp: 32'hAAAA5678};
        v[2] = '{m: 1'b1, we: 1'b0, addr: 32'h20, sel: 4'hF, wdata: 32'h0,        exp: 32'hAAAA5678};
        v[3] = '{m: 1'b0, we: 1'b1, addr: 32'h40, sel: 4'hC, wdata: 32'hCAFEF00D, exp: 32'hCAFE4040};
        v[4] = '{m: 1'b0, we: 1'b0, addr: 32'h40, sel: 4'hF, wdata: 32'h0,        exp: 32'hCAFE4040};
        v[5] = '{m: 1'b1, we: 1'b1, addr: 32'h44, sel: 4'hF, wdata: 32'h01020304, exp: 32'h01020304};

        do_reset();

        // single transfers from the table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            drive(v[i].m, 1'b1, v[i].we, v[i].addr, v[i].sel, v[i].wdata, 1'b0);
            tgt = n_ack + 1;
            expect_ack(v[i].m, cyc + 2, v[i].we, v[i].exp);
            #1 chk("vec_stall_req", 32'(v[i].m ? m1_stall_o : m0_stall_o), 32'd1);
            @(negedge clk);
            chk("vec_ce", 32'(ram_ce_o), 32'd1);
            chk("vec_we", 32'(ram_we_o), 32'(v[i].we));
            chk("vec_addr", ram_addr_o, v[i].addr);
            chk("vec_sel", 32'(ram_sel_o), 32'(v[i].sel));
            chk("vec_stall_acc", 32'(v[i].m ? m1_stall_o : m0_stall_o), 32'd1);
            if (v[i].we) chk("vec_wdata", ram_data_o, v[i].wdata);
            wait_ack(tgt);
            chk("vec_stall_ack", 32'(v[i].m ? m1_stall_o : m0_stall_o), 32'd0);
            drive(v[i].m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
            @(negedge clk);
            chk("vec_ce_idle", 32'(ram_ce_o), 32'd0);
            if (v[i].we) chk("vec_mem", mem[v[i].addr[9:2]], v[i].exp);
        end

        // both masters request continuously from reset: m0, m1, m0, m1
        do_reset();
        @(negedge clk);
        #1;
        c = cyc;
        tgt = n_ack + 4;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++)
            expect_ack(k[0], c + 2 + 3 * k, 1'b0, k[0] ? 32'hAAAA5678 : 32'hDEADBEEF);
        wait_ack(tgt);
        idle_all();

        // m0 locked and continuous against m1: four m0 grants, then m1, then m0
        do_reset();
        @(negedge clk);
        #1;
        c = cyc;
        tgt = n_ack + 6;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++)
            expect_ack(k == 4, c + 2 + 3 * k, 1'b0, (k == 4) ? 32'hAAAA5678 : 32'hDEADBEEF);
        wait_ack(tgt);
        idle_all();

        // lock released when the owner drops req in IDLE; m1 granted in that same cycle
        do_reset();
        @(negedge clk);
        #1;
        tgt = n_ack + 1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1);
        expect_ack(1'b0, cyc + 2, 1'b0, 32'hDEADBEEF);
        wait_ack(tgt);
        c = cyc;
        tgt = n_ack + 1;
        m0_req_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        expect_ack(1'b1, c + 3, 1'b0, 32'hAAAA5678);
        @(negedge clk);
        chk("unlock_idle_ce", 32'(ram_ce_o), 32'd0);
        @(negedge clk);
        chk("unlock_grant_ce", 32'(ram_ce_o), 32'd1);
        chk("unlock_grant_addr", ram_addr_o, 32'h20);
        wait_ack(tgt);
        idle_all();

        // reset during ACCESS of an m1 write: no commit, no ack, then a normal m0 read
        @(negedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h55555555, 1'b0);
        @(negedge clk);
        chk("rstacc_ce", 32'(ram_ce_o), 32'd1);
        #1 rst = 1'b1;
        idle_all();
        #1 chk("rstacc_ce_forced", 32'(ram_ce_o), 32'd0);
        @(negedge clk);
        chk("rstacc_ram", 32'(|{ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o}), 32'd0);
        chk("rstacc_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        chk("rstacc_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
        #1 rst = 1'b0;
        last_rd[0] = 0;
        last_rd[1] = 0;
        @(negedge clk);
        chk("rstacc_mem", mem[8'h0C], 32'h30303030);
        #1;
        tgt = n_ack + 1;
        drive(1'b0, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0);
        expect_ack(1'b0, cyc + 2, 1'b0, 32'h30303030);
        wait_ack(tgt);
        idle_all();

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
